if_fetch: RTL and testbench

Instruction-fetch stage of the toy RISC-V pipeline. It holds the PC and looks it up in a small direct-mapped instruction cache. On a miss it refills one 32-bit word over the shared byte-wide memory port, arbitrated against MEM. The block drives `if_stall` into the stall bus and obeys `stall_signal[0]` when presenting instructions to the IF/ID latch.

---
 rtl/cpu_defs.sv | 15 +
 rtl/icache_dm.sv | 47 ++++
 rtl/if_fetch.sv | 198 +++++++++++++++++++
 tb/tb_if_fetch.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared definitions for the toy RISC-V pipeline: instruction width,
// default reset PC, fetch FSM encoding and stall-bus bit positions.
package cpu_defs;

    localparam int          INST_W       = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    // Fetch FSM encoding
    localparam logic [0:0]  S_IDLE       = 1'b0;
    localparam logic [0:0]  S_REFILL     = 1'b1;

    // Stall bus bit that holds the IF stage
    localparam int          STALL_IF     = 0;

endpackage

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache, one 32-bit word per line.
// Combinational read on index, synchronous single write port,
// valid bits cleared synchronously on active-low reset.
module icache_dm
    import cpu_defs::*;
#(
    parameter int LINES = 64,
    parameter int IDX_W = $clog2(LINES),
    parameter int TAG_W = 32 - IDX_W - 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [TAG_W-1:0]  rd_tag,
    output logic              rd_hit,
    output logic [INST_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [INST_W-1:0] wr_data
);

    logic [LINES-1:0]  valid_r;
    logic [TAG_W-1:0]  tag_r  [LINES];
    logic [INST_W-1:0] data_r [LINES];

    // Valid bits: wiped on reset, set when a line is filled
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_r <= '0;
        end else if (wr_en) begin
            valid_r[wr_idx] <= 1'b1;
        end
    end

    // Tag and data arrays: no reset needed, the valid bit gates their use
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_r[wr_idx]  <= wr_tag;
            data_r[wr_idx] <= wr_data;
        end
    end

    assign rd_hit  = valid_r[rd_idx] && (tag_r[rd_idx] == rd_tag);
    assign rd_data = data_r[rd_idx];

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC register, direct-mapped I-cache lookup and a
// byte-serial refill engine on the shared memory port. Redirects from EX
// always win; stall_signal[STALL_IF] freezes the IF/ID outputs only, so a
// refill keeps running underneath a stall.
module if_fetch
    import cpu_defs::*;
#(
    parameter int          ICACHE_LINES = 64,
    parameter logic [31:0] RESET_PC     = RESET_PC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        stall_signal,
    input  logic              branch_flag,
    input  logic [31:0]       branch_target,
    output logic              mem_req,
    output logic [31:0]       mem_addr,
    input  logic              mem_grant,
    input  logic [7:0]        mem_din,
    output logic [31:0]       if_pc,
    output logic [INST_W-1:0] if_inst,
    output logic              if_valid,
    output logic              if_stall
);

    localparam int IDX_W = $clog2(ICACHE_LINES);
    localparam int TAG_W = 32 - IDX_W - 2;

    // Registered state
    logic [0:0]        state_r;
    logic [31:0]       pc_r;
    logic [2:0]        ic_r;        // bytes issued in current refill
    logic [2:0]        rc_r;        // bytes received in current refill
    logic [31:0]       line_r;      // line assembly buffer
    logic              grant_d_r;   // a byte is due on mem_din this cycle
    logic              mem_req_r;
    logic [31:0]       mem_addr_r;
    logic [31:0]       if_pc_r;
    logic [INST_W-1:0] if_inst_r;
    logic              if_valid_r;

    // Next-state values
    logic [0:0]        state_s;
    logic [31:0]       pc_s;
    logic [2:0]        ic_s;
    logic [2:0]        rc_s;
    logic [31:0]       line_s;
    logic              grant_d_s;
    logic              mem_req_s;
    logic [31:0]       mem_addr_s;
    logic [31:0]       if_pc_s;
    logic [INST_W-1:0] if_inst_s;
    logic              if_valid_s;

    // Cache interface
    logic              hit_s;
    logic [INST_W-1:0] rd_data_s;
    logic              cache_wr_s;
    logic              stall_if_s;
    logic              unused_stall_s;

    assign stall_if_s     = stall_signal[STALL_IF];
    assign unused_stall_s = ^stall_signal;

    icache_dm #(
        .LINES (ICACHE_LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_icache (
        .clk     (clk),
        .rst     (rst),
        .rd_idx  (pc_r[IDX_W+1:2]),
        .rd_tag  (pc_r[31:IDX_W+2]),
        .rd_hit  (hit_s),
        .rd_data (rd_data_s),
        .wr_en   (cache_wr_s),
        .wr_idx  (pc_r[IDX_W+1:2]),
        .wr_tag  (pc_r[31:IDX_W+2]),
        .wr_data (line_s)
    );

    // Next-state logic: redirect first, then lookup / refill sequencing
    always_comb begin
        state_s    = state_r;
        pc_s       = pc_r;
        ic_s       = ic_r;
        rc_s       = rc_r;
        line_s     = line_r;
        grant_d_s  = 1'b0;
        cache_wr_s = 1'b0;
        if_pc_s    = if_pc_r;
        if_inst_s  = if_inst_r;
        if_valid_s = if_valid_r;

        if (branch_flag) begin
            // Drop any partial line; the byte still in flight is ignored
            // because grant_d_s stays low.
            pc_s       = branch_target;
            if_valid_s = 1'b0;
            state_s    = S_IDLE;
            ic_s       = 3'd0;
            rc_s       = 3'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (hit_s) begin
                        if (!stall_if_s) begin
                            if_inst_s  = rd_data_s;
                            if_pc_s    = pc_r;
                            if_valid_s = 1'b1;
                            pc_s       = pc_r + 32'd4;
                        end else begin
                            if_valid_s = if_valid_r;
                        end
                    end else begin
                        state_s = S_REFILL;
                        ic_s    = 3'd0;
                        rc_s    = 3'd0;
                        if (!stall_if_s) begin
                            if_valid_s = 1'b0;
                        end else begin
                            if_valid_s = if_valid_r;
                        end
                    end
                end
                S_REFILL: begin
                    if (mem_req_r && mem_grant) begin
                        ic_s      = ic_r + 3'd1;
                        grant_d_s = 1'b1;
                    end else begin
                        ic_s      = ic_r;
                    end
                    if (grant_d_r) begin
                        line_s[{rc_r[1:0], 3'b000} +: 8] = mem_din;
                        rc_s = rc_r + 3'd1;
                        if (rc_r == 3'd3) begin
                            cache_wr_s = 1'b1;
                            state_s    = S_IDLE;
                        end else begin
                            state_s    = S_REFILL;
                        end
                    end else begin
                        rc_s = rc_r;
                    end
                    if (!stall_if_s) begin
                        if_valid_s = 1'b0;
                    end else begin
                        if_valid_s = if_valid_r;
                    end
                end
                default: begin
                    state_s = S_IDLE;
                end
            endcase
        end

        // Request is registered: decide next cycle's byte from next-state
        mem_req_s  = (state_s == S_REFILL) && (ic_s < 3'd4);
        mem_addr_s = mem_req_s ? (pc_s + {29'd0, ic_s}) : 32'd0;
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= S_IDLE;
            pc_r       <= RESET_PC;
            ic_r       <= 3'd0;
            rc_r       <= 3'd0;
            line_r     <= 32'd0;
            grant_d_r  <= 1'b0;
            mem_req_r  <= 1'b0;
            mem_addr_r <= 32'd0;
            if_pc_r    <= 32'd0;
            if_inst_r  <= '0;
            if_valid_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            ic_r       <= ic_s;
            rc_r       <= rc_s;
            line_r     <= line_s;
            grant_d_r  <= grant_d_s;
            mem_req_r  <= mem_req_s;
            mem_addr_r <= mem_addr_s;
            if_pc_r    <= if_pc_s;
            if_inst_r  <= if_inst_s;
            if_valid_r <= if_valid_s;
        end
    end

    assign mem_req  = mem_req_r;
    assign mem_addr = mem_addr_r;
    assign if_pc    = if_pc_r;
    assign if_inst  = if_inst_r;
    assign if_valid = if_valid_r;
    assign if_stall = !rst || (state_r != S_IDLE) || !hit_s;

endmodule

// File: tb/tb_if_fetch.sv
// Directed testbench for if_fetch: byte-wide memory model with one-cycle
// return latency, hand-computed expectations checked with immediate asserts.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  stall_signal;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_grant;
    logic [7:0]  mem_din;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;
    logic        if_stall;

    int tests = 0;
    int fails = 0;

    localparam logic [31:0] W0  = 32'h0000_0013;
    localparam logic [31:0] W1  = 32'h0010_0093;
    localparam logic [31:0] W2  = 32'h0020_0113;
    localparam logic [31:0] W3  = 32'h0030_0193;
    localparam logic [31:0] W40 = 32'hDEAD_BEEF;

    logic [31:0] words [4];
    logic [7:0]  mem [256];
    logic [7:0]  pend_byte = 8'h00;

    always #5 clk = ~clk;

    if_fetch #(
        .ICACHE_LINES (64),
        .RESET_PC     (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_signal  (stall_signal),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_grant     (mem_grant),
        .mem_din       (mem_din),
        .if_pc         (if_pc),
        .if_inst       (if_inst),
        .if_valid      (if_valid),
        .if_stall      (if_stall)
    );

    // Memory model: byte for a grant in cycle t is presented during t+1
    always @(negedge clk) begin
        mem_din   = pend_byte;
        pend_byte = (mem_req && mem_grant) ? mem[mem_addr[7:0]] : 8'h00;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load_word(input int addr, input logic [31:0] w);
        mem[addr]     = w[7:0];
        mem[addr + 1] = w[15:8];
        mem[addr + 2] = w[23:16];
        mem[addr + 3] = w[31:24];
    endtask

    task automatic branch_to(input logic [31:0] target);
        branch_flag   = 1'b1;
        branch_target = target;
        tick();
        branch_flag   = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!if_valid && n < budget);
        chk("wait_valid", {31'd0, if_valid}, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        load_word(32'h00, W0);
        load_word(32'h04, W1);
        load_word(32'h08, W2);
        load_word(32'h0C, W3);
        load_word(32'h40, W40);
        words[0] = W0; words[1] = W1; words[2] = W2; words[3] = W3;

        rst = 1'b0; stall_signal = 5'd0; branch_flag = 1'b0;
        branch_target = 32'd0; mem_grant = 1'b1;
        tick();
        tick();

        // Reset state
        chk("rst_if_pc",    if_pc,              32'd0);
        chk("rst_if_inst",  if_inst,            32'd0);
        chk("rst_if_valid", {31'd0, if_valid},  32'd0);
        chk("rst_mem_req",  {31'd0, mem_req},   32'd0);
        chk("rst_mem_addr", mem_addr,           32'd0);
        chk("rst_if_stall", {31'd0, if_stall},  32'd1);

        // Cold start: lookup, 4 issue cycles, final receive, hit, output
        rst = 1'b1;
        chk("cold_stall_c1", {31'd0, if_stall}, 32'd1);
        chk("cold_req_c1",   {31'd0, mem_req},  32'd0);
        for (int c = 2; c <= 6; c++) begin
            tick();
            chk("cold_stall", {31'd0, if_stall}, 32'd1);
            if (c <= 5) begin
                chk("cold_req",  {31'd0, mem_req}, 32'd1);
                chk("cold_addr", mem_addr,         32'(c - 2));
            end else begin
                chk("cold_req_done", {31'd0, mem_req}, 32'd0);
            end
        end
        tick();
        chk("cold_hit_stall", {31'd0, if_stall}, 32'd0);
        chk("cold_hit_valid", {31'd0, if_valid}, 32'd0);
        tick();
        chk("cold_inst",  if_inst,           W0);
        chk("cold_pc",    if_pc,             32'd0);
        chk("cold_valid", {31'd0, if_valid}, 32'd1);
        chk("pc4_miss",   {31'd0, if_stall}, 32'd1);

        // Refill of PC 4 starts; reset lands in the middle of it
        tick(); chk("pc4_addr0", mem_addr, 32'h4);
        tick(); chk("pc4_addr1", mem_addr, 32'h5);
        tick(); chk("pc4_addr2", mem_addr, 32'h6);
        rst = 1'b0;
        tick();
        chk("mrst_if_pc",    if_pc,             32'd0);
        chk("mrst_if_inst",  if_inst,           32'd0);
        chk("mrst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("mrst_mem_req",  {31'd0, mem_req},  32'd0);
        chk("mrst_mem_addr", mem_addr,          32'd0);
        rst = 1'b1;
        chk("mrst_line0_invalid", {31'd0, if_stall}, 32'd1);

        // Restart at RESET_PC with the second issue denied for 3 cycles
        tick(); chk("deny_addr0", mem_addr, 32'h0);
        tick(); chk("deny_addr1_a", mem_addr, 32'h1);
        mem_grant = 1'b0;
        tick(); chk("deny_addr1_b", mem_addr, 32'h1);
        tick(); chk("deny_addr1_c", mem_addr, 32'h1);
        tick(); chk("deny_addr1_d", mem_addr, 32'h1);
        chk("deny_req_held", {31'd0, mem_req}, 32'd1);
        mem_grant = 1'b1;
        tick(); chk("deny_addr2", mem_addr, 32'h2);
        tick(); chk("deny_addr3", mem_addr, 32'h3);
        tick(); chk("deny_rx_stall", {31'd0, if_stall}, 32'd1);
        tick(); chk("deny_hit_stall", {31'd0, if_stall}, 32'd0);
        tick();
        chk("deny_inst",  if_inst,           W0);
        chk("deny_pc",    if_pc,             32'd0);
        chk("deny_valid", {31'd0, if_valid}, 32'd1);

        // Redirect to 0x40 during the 3rd refill byte of PC 0x8
        branch_to(32'h8);
        chk("br8_valid", {31'd0, if_valid}, 32'd0);
        tick(); chk("br8_addr0", mem_addr, 32'h8);
        tick(); chk("br8_addr1", mem_addr, 32'h9);
        tick(); chk("br8_addr2", mem_addr, 32'hA);
        branch_to(32'h40);
        chk("br40_valid", {31'd0, if_valid}, 32'd0);
        chk("br40_req",   {31'd0, mem_req},  32'd0);
        chk("br40_stall", {31'd0, if_stall}, 32'd1);
        tick();
        chk("br40_req1",  {31'd0, mem_req},  32'd1);
        chk("br40_addr",  mem_addr,          32'h40);
        wait_valid(20);
        chk("br40_pc",   if_pc,   32'h40);
        chk("br40_inst", if_inst, W40);
        branch_to(32'h8);
        chk("line8_invalid", {31'd0, if_stall}, 32'd1);
        tick();
        chk("line8_refetch", mem_addr, 32'h8);
        wait_valid(20);
        chk("pc8_pc",   if_pc,   32'h8);
        chk("pc8_inst", if_inst, W2);

        // Loop of 4 instructions: first pass fills lines 4 and C
        branch_to(32'h4);
        wait_valid(20); chk("p1_pc4", if_pc, 32'h4); chk("p1_inst4", if_inst, W1);
        wait_valid(20); chk("p1_pc8", if_pc, 32'h8); chk("p1_inst8", if_inst, W2);
        wait_valid(20); chk("p1_pcC", if_pc, 32'hC); chk("p1_instC", if_inst, W3);
        branch_to(32'h0);
        chk("p2_bubble", {31'd0, if_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("p2_stall", {31'd0, if_stall}, 32'd0);
            tick();
            chk("p2_valid", {31'd0, if_valid}, 32'd1);
            chk("p2_pc",    if_pc,             32'(4 * i));
            chk("p2_inst",  if_inst,           words[i]);
        end

        // Stall held for 4 cycles on a hit, then resume at pc+4
        branch_to(32'h0);
        tick();
        chk("st_pc0", if_pc, 32'h0);
        stall_signal = 5'b11111;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("st_hold_pc",    if_pc,             32'h0);
            chk("st_hold_inst",  if_inst,           W0);
            chk("st_hold_valid", {31'd0, if_valid}, 32'd1);
            chk("st_if_stall",   {31'd0, if_stall}, 32'd0);
        end
        stall_signal = 5'd0;
        tick();
        chk("st_resume_pc",   if_pc,   32'h4);
        chk("st_resume_inst", if_inst, W1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
